// File: rtl/gpu_prog_mem.sv
// Double-buffered instruction memory for the gpu fetch path: a streaming load
// fills the shadow bank, and a frame-boundary swap makes it the active bank.
module gpu_prog_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned BANKS      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [DATA_WIDTH-1:0]       ld_data,
    input  logic                        ld_last,
    input  logic                        swap_req,
    output logic                        swap_done,
    output logic [$clog2(BANKS)-1:0]    active_bank,
    output logic [$clog2(DEPTH):0]      loaded_words,
    output logic                        busy,
    output logic                        err_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = $clog2(BANKS);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        PEND
    } state_t;

    state_t state, state_n;

    logic [AW:0]             fill_addr, fill_addr_n;
    logic [AW:0]             loaded_n;
    logic [BW-1:0]           bank_n;
    logic [BW-1:0]           target;
    logic                    swap_n;
    logic                    ovf_n;

    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    in_range;

    logic [DATA_WIDTH-1:0]   mem [BANKS*DEPTH];

    always_comb begin
        if (active_bank == BW'(BANKS-1)) begin
            target = '0;
        end else begin
            target = active_bank + 1'b1;
        end
    end

    // Handshake and busy decode directly from the state register only.
    assign ld_ready = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n     = state;
        loaded_n    = loaded_words;
        fill_addr_n = fill_addr;
        bank_n      = active_bank;
        swap_n      = 1'b0;
        ovf_n       = err_overflow;
        wr_en       = 1'b0;
        wr_addr     = fill_addr[AW-1:0];
        wr_data     = '0;

        unique case (state)
            IDLE, LOAD: begin
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    wr_data = ld_data;
                    if (state == IDLE) begin
                        wr_addr  = '0;
                        loaded_n = (AW+1)'(1);
                    end else begin
                        wr_addr  = loaded_words[AW-1:0];
                        loaded_n = loaded_words + 1'b1;
                    end
                    fill_addr_n = loaded_n;
                    // A full bank needs no zero fill; a missing ld_last there is an overflow.
                    if (loaded_n == FULL) begin
                        state_n = PEND;
                        if (!ld_last) begin
                            ovf_n = 1'b1;
                        end
                    end else if (ld_last) begin
                        state_n = FILL;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            FILL: begin
                wr_en       = 1'b1;
                wr_addr     = fill_addr[AW-1:0];
                wr_data     = '0;
                fill_addr_n = fill_addr + 1'b1;
                if (fill_addr == FULL - 1'b1) begin
                    state_n = PEND;
                end
            end
            PEND: begin
                if (swap_req) begin
                    bank_n  = target;
                    swap_n  = 1'b1;
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            loaded_words <= '0;
            fill_addr    <= '0;
            active_bank  <= '0;
            swap_done    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            loaded_words <= loaded_n;
            fill_addr    <= fill_addr_n;
            active_bank  <= bank_n;
            swap_done    <= swap_n;
            err_overflow <= ovf_n;
        end
    end

    // Writes only ever reach the shadow bank, so no read/write collision exists.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[{target, wr_addr}] <= wr_data;
        end
    end

    assign in_range = ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (in_range) begin
            rd_data <= mem[{active_bank, rd_addr[AW-1:0]}];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: doc/gpu_prog_mem.md
# gpu_prog_mem

Banked, double-buffered program/frame memory that feeds instruction words to the `gpu` core through its `input_addr`/`data_input` fetch path. A streaming load port fills a shadow bank while the core executes from the active bank. Unwritten tail words are zero-filled so the core fetches NOPs past the end of a program. The shadow bank becomes active only on an explicit frame-boundary swap request, so a fetch never sees a half-loaded program.

## Interface
- `DATA_WIDTH`, 16: instruction word width.
- `ADDR_WIDTH`, 20: fetch address width; matches the core's `input_addr`.
- `DEPTH`, 1024: words per bank; power of two, at most 2^ADDR_WIDTH.
- `BANKS`, 2: number of banks; at least 2.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_addr`  in  ADDR_WIDTH  fetch address from the core.
- `rd_data`  out  DATA_WIDTH  fetched word; registered.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid && ld_ready`.
- `ld_data`  in  DATA_WIDTH  load word.
- `ld_last`  in  1  marks the final beat of a program.
- `swap_req`  in  1  frame-boundary pulse from the core.
- `swap_done`  out  1  one-cycle pulse when the banks swap.
- `active_bank`  out  clog2(BANKS)  bank currently served to `rd_data`.
- `loaded_words`  out  clog2(DEPTH)+1  beats accepted in the current or last load.
- `busy`  out  1  high in LOAD, FILL and PEND.
- `err_overflow`  out  1  sticky; cleared only by `rst`.

## Operation
- **Banks.**
  - Load target is `(active_bank+1) mod BANKS`.
  - Reads always come from `active_bank`.
- **FSM states.** IDLE, LOAD, FILL, PEND.
- **IDLE.**
  - `ld_ready`=1.
  - An accepted beat writes word 0 of the target bank, sets `loaded_words`=1 and moves to LOAD.
  - If that beat also has `ld_last`, go straight to FILL.
- **LOAD.**
  - `ld_ready`=1.
  - Each accepted beat writes at address `loaded_words`, then increments it.
  - A beat with `ld_last` moves to FILL.
  - If the beat writing address DEPTH-1 has no `ld_last`, treat it as last: set `err_overflow`, go to FILL.
- **FILL.**
  - `ld_ready`=0.
  - Write 0 to one address per cycle, from `loaded_words` up to DEPTH-1, then go to PEND.
  - If `loaded_words`==DEPTH, FILL lasts 0 cycles: go directly to PEND.
- **PEND.**
  - `ld_ready`=0; waits for `swap_req`.
  - On `swap_req`: `active_bank` advances to the target bank, `swap_done` pulses, go to IDLE.
- **Ignored `swap_req`.** In IDLE, LOAD and FILL, `swap_req` is dropped (not queued). The active bank keeps repeating the current program.
- **Out-of-range fetch.** `rd_addr` >= DEPTH returns 0.
- **Width rule.** Only the low clog2(DEPTH) bits index memory; any higher set bit forces zero.
- **Reset.**
  - All state and outputs clear: `rd_data`=0, `ld_ready`=1 (IDLE), `swap_done`=0, `active_bank`=0, `loaded_words`=0, `busy`=0, `err_overflow`=0.
  - Memory contents are not cleared; bank 0 is undefined until loaded and swapped in.
- **Reset mid-load.** Returns to IDLE; the partial shadow bank is discarded and bank 0 becomes active.

## Timing
- **Read latency.** 1 cycle. `rd_data` at edge N+1 reflects `rd_addr` and `active_bank` sampled at edge N.
- **Read at the swap edge.** A read sampled at the swap edge uses the old bank; reads from the next edge use the new bank.
- **Load handshake.**
  - `ld_ready` is a registered function of state only; it never depends on `ld_valid` combinationally.
  - No beat is lost when `ld_ready` falls: the accepting edge is the last beat.
- **Load duration.** An n-beat load with `ld_last` reaches PEND after n + (DEPTH−n) cycles from the first accepted beat, plus one state-transition cycle.
- **Swap latency.**
  - `swap_req` sampled high in PEND: `active_bank` and `swap_done` update at that edge.
  - `ld_ready` is 1 on the next cycle.
- **Simultaneous events.**
  - `swap_req` in the same cycle as the FILL→PEND transition is ignored; swap only from a registered PEND.
  - A write never targets the active bank, so read and write can never hit the same address.

## Test plan
- Reset, load 288 beats 0x0001..0x0120 (last on beat 288), pulse `swap_req` in PEND -> `swap_done` 1 cycle; fetch 0..287 returns 0x0001..0x0120 one cycle after each address; fetch 288..1023 returns 0x0000; `active_bank`=1.
- Load program B while fetching A continuously -> every fetch during LOAD/FILL returns A data; swap -> first fetch after the swap edge returns B word; `active_bank`=0.
- Send 1030 beats without `ld_last` -> beats 0..1023 accepted, `ld_ready`=0 after beat 1023, `err_overflow`=1, no FILL cycles, PEND reached.
- Pulse `swap_req` in IDLE, LOAD and FILL -> no `swap_done`, `active_bank` unchanged; pulse again in PEND -> swap occurs.
- Assert `rst` midway through a 500-beat load -> all outputs at reset values next cycle, `ld_ready`=1, new 10-beat load plus swap serves the new program with zeros at 10..1023.
- Fetch `rd_addr`=0x00400 and 0xFFFFF -> `rd_data`=0; randomized `ld_valid` gaps over a 300-beat load -> contents exact, `loaded_words`=300.
